// File: rtl/output_port_demux.sv
// output_port_demux: steers merged AXI4-Stream packets to per-port TX queues by one-hot tuser[31:24] (multicast when OUTPUT_DEMUX_MCAST_EN is defined).
// Latency: 1 cycle from input accept to m_axis_tvalid_N through a single shared beat register.
// Backpressure: input stalls until every targeted port has taken the staged beat; dropped packets drain at full rate.
module output_port_demux #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 5,
    parameter int C_CNTR_WIDTH       = 32
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_0,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
    output logic                            m_axis_tlast_0,
    output logic                            m_axis_tvalid_0,
    input  logic                            m_axis_tready_0,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_1,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
    output logic                            m_axis_tlast_1,
    output logic                            m_axis_tvalid_1,
    input  logic                            m_axis_tready_1,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_2,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
    output logic                            m_axis_tlast_2,
    output logic                            m_axis_tvalid_2,
    input  logic                            m_axis_tready_2,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_3,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
    output logic                            m_axis_tlast_3,
    output logic                            m_axis_tvalid_3,
    input  logic                            m_axis_tready_3,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_4,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_4,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_4,
    output logic                            m_axis_tlast_4,
    output logic                            m_axis_tvalid_4,
    input  logic                            m_axis_tready_4,
    input  logic                            rst_cntrs,
    output logic [C_CNTR_WIDTH-1:0]         pkt_fwd_cntr,
    output logic [C_CNTR_WIDTH-1:0]         pkt_drop_cntr
);

    localparam logic [C_CNTR_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    state_t                         state_q, state_d;
    logic [NUM_QUEUES-1:0]          dst_raw, dst_sel, dst_reg, cur_dst;
    logic [NUM_QUEUES-1:0]          pend_q, pend_d, rdy_vec;
    logic [4:0]                     rdy5, pend5;
    logic                           stage_free, accept, load, pkt_has_dst;

    logic [C_AXIS_DATA_WIDTH-1:0]   stg_data;
    logic [C_AXIS_DATA_WIDTH/8-1:0] stg_strb;
    logic [C_AXIS_TUSER_WIDTH-1:0]  stg_user;
    logic                           stg_last;

    assign rdy5    = {m_axis_tready_4, m_axis_tready_3, m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};
    assign rdy_vec = rdy5[NUM_QUEUES-1:0];
    assign pend5   = 5'(pend_q);
    assign dst_raw = s_axis_tuser[24 +: NUM_QUEUES];

`ifdef OUTPUT_DEMUX_MCAST_EN
    assign dst_sel = dst_raw;
`else
    // Unicast build keeps only the lowest-numbered requested port.
    always_comb begin
        dst_sel = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (dst_raw[i]) begin
                dst_sel    = '0;
                dst_sel[i] = 1'b1;
            end
        end
    end
`endif

    // The stage can take a new beat if every still-pending port is ready now.
    assign stage_free = ((pend_q & ~rdy_vec) == '0);
    assign cur_dst    = (state_q == IDLE) ? dst_sel : dst_reg;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !s_axis_tlast) begin
                    state_d = (dst_sel != '0) ? PKT : DROP;
                end
            end
            PKT, DROP: begin
                if (accept && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = ~axi_reset & ((state_q == DROP) | stage_free);
        accept        = s_axis_tvalid & s_axis_tready;
        load          = accept & (state_q != DROP) & (cur_dst != '0);
        pkt_has_dst   = (state_q == IDLE) ? (dst_sel != '0) : (state_q == PKT);
        pend_d        = load ? cur_dst : (pend_q & ~rdy_vec);
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            pend_q  <= '0;
            dst_reg <= '0;
        end else begin
            pend_q <= pend_d;
            if (accept && state_q == IDLE) begin
                dst_reg <= dst_sel;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (load) begin
            stg_data <= s_axis_tdata;
            stg_strb <= s_axis_tstrb;
            stg_user <= s_axis_tuser;
            stg_last <= s_axis_tlast;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset || rst_cntrs) begin
            pkt_fwd_cntr  <= '0;
            pkt_drop_cntr <= '0;
        end else if (accept && s_axis_tlast) begin
            if (pkt_has_dst) begin
                if (pkt_fwd_cntr != '1) pkt_fwd_cntr <= pkt_fwd_cntr + CNT_ONE;
            end else begin
                if (pkt_drop_cntr != '1) pkt_drop_cntr <= pkt_drop_cntr + CNT_ONE;
            end
        end
    end

    assign m_axis_tvalid_0 = pend5[0];
    assign m_axis_tvalid_1 = pend5[1];
    assign m_axis_tvalid_2 = pend5[2];
    assign m_axis_tvalid_3 = pend5[3];
    assign m_axis_tvalid_4 = pend5[4];

    assign m_axis_tdata_0 = stg_data;
    assign m_axis_tdata_1 = stg_data;
    assign m_axis_tdata_2 = stg_data;
    assign m_axis_tdata_3 = stg_data;
    assign m_axis_tdata_4 = stg_data;

    assign m_axis_tstrb_0 = stg_strb;
    assign m_axis_tstrb_1 = stg_strb;
    assign m_axis_tstrb_2 = stg_strb;
    assign m_axis_tstrb_3 = stg_strb;
    assign m_axis_tstrb_4 = stg_strb;

    assign m_axis_tuser_0 = stg_user;
    assign m_axis_tuser_1 = stg_user;
    assign m_axis_tuser_2 = stg_user;
    assign m_axis_tuser_3 = stg_user;
    assign m_axis_tuser_4 = stg_user;

    assign m_axis_tlast_0 = stg_last;
    assign m_axis_tlast_1 = stg_last;
    assign m_axis_tlast_2 = stg_last;
    assign m_axis_tlast_3 = stg_last;
    assign m_axis_tlast_4 = stg_last;

endmodule
